button_counter_ctrl: RTL
========================

BUTTON_COUNTER_CTRL -- requirements
Module: button_counter_ctrl

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 50000, meaning clocks an input must be stable to be accepted (1 ms at 50 MHz); legal range 2..2^20-1.
REQ-002 SHALL have parameter CNT_WIDTH, default 4, meaning counter width (one bit per lamp).
REQ-003 SHALL have port clk, input, 1 bit: single system clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1 bit: reset, synchronous, active-high.
REQ-005 SHALL have port i_btn, input, 3 bits: raw board buttons, active-low (0 = pressed), asynchronous to clk; [0]=up, [1]=down, [2]=clear.
REQ-006 SHALL have port o_btn_state, output, 3 bits: debounced level per button, 1 = pressed.
REQ-007 SHALL have port o_press, output, 3 bits: one-cycle pulse per button on each debounced press.
REQ-008 SHALL have port o_count, output, CNT_WIDTH bits: counter value, drives the lamps directly.
REQ-009 SHALL have port o_wrap, output, 1 bit: one-cycle pulse when the counter wraps in either direction.

Function
REQ-010 SHALL pass each i_btn bit through a two-flop synchronizer before any other use.
REQ-011 SHALL keep one debounce counter per button, cleared whenever the synchronized level equals that button's o_btn_state.
REQ-012 SHALL increment the debounce counter each cycle the synchronized level differs from o_btn_state.
REQ-013 SHALL toggle o_btn_state when the debounce counter reaches DEBOUNCE_CYCLES-1, and clear that counter in the same cycle.
REQ-014 SHALL ignore any input glitch shorter than DEBOUNCE_CYCLES consecutive cycles; o_btn_state and o_press stay unchanged.
REQ-015 SHALL register o_press[i] high for exactly one cycle following the 0->1 transition of o_btn_state[i]; release (1->0) produces no pulse.
REQ-016 SHALL give a total latency of DEBOUNCE_CYCLES+3 rising edges, clean input edge to o_press high (2 sync + DEBOUNCE_CYCLES + 1 register).
REQ-017 SHALL update o_count on the rising edge following the cycle in which o_press is high.
REQ-018 SHALL resolve counter actions per cycle by priority: clear press -> 0; else up and down together -> no change; else up -> +1; else down -> -1.
REQ-019 SHALL perform arithmetic modulo 2^CNT_WIDTH unless REQ-030 applies.
REQ-020 SHALL pulse o_wrap for one cycle, coincident with the o_count update, when up moves max->0 or down moves 0->max.
REQ-021 SHALL never assert o_wrap on a clear press, even from max.
REQ-022 SHALL produce exactly one count step per press however long the button is held; no auto-repeat.

Reset
REQ-023 SHALL, on rst=1 at a rising edge, set o_count=0, o_press=0, o_wrap=0, o_btn_state=0, all debounce counters=0 and synchronizer flops=1 (released).
REQ-024 SHALL give rst priority over any press pulse in the same cycle; the pending press is discarded.
REQ-025 SHALL re-qualify a button held through reset: after rst falls it needs a full DEBOUNCE_CYCLES and then yields one press.
REQ-026 SHALL keep all outputs registered; no combinational path from i_btn to any output.

Configuration
REQ-027 SHALL recognise macro BTN_COUNTER_SATURATE_EN.
REQ-028 SHALL, without the macro, wrap o_count per REQ-019/REQ-020.
REQ-029 SHALL, with the macro defined, saturate: up at max and down at 0 leave o_count unchanged.
REQ-030 SHALL, with the macro defined, tie o_wrap to 0 permanently.
REQ-031 SHALL keep clear and all debounce behaviour identical with or without the macro.

Verification (DEBOUNCE_CYCLES=4, CNT_WIDTH=4)
REQ-032 SHALL test basic press: rst then i_btn[0] low, held 20 cycles -> o_press[0] high exactly 7 edges after the change, for 1 cycle; o_count 0->1; no further change while held.
REQ-033 SHALL test bounce: i_btn[1] low 3 cycles, high 2, low 3, then high -> no o_press, o_count unchanged.
REQ-034 SHALL test wrap: o_count=15, press up -> o_count=0 with o_wrap 1 cycle; at 0, press down -> 15 with o_wrap; with BTN_COUNTER_SATURATE_EN: 15 stays 15, 0 stays 0, o_wrap never high.
REQ-035 SHALL test simultaneous events: up+down released together at o_count=5 -> stays 5; up+clear together at 9 -> 0, no o_wrap.
REQ-036 SHALL test reset mid-operation: rst asserted in the o_press cycle at o_count=3 -> o_count=0 afterwards, no increment; button still held -> one press after DEBOUNCE_CYCLES+3 -> o_count=1.

Source files
------------

// File: rtl/button_counter_ctrl.sv
// button_counter_ctrl: debounced up/down/clear buttons driving a lamp counter.
// Define BTN_COUNTER_SATURATE_EN to saturate at 0/max instead of wrapping.
module button_counter_ctrl #(
    parameter int DEBOUNCE_CYCLES = 50000,
    parameter int CNT_WIDTH       = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [2:0]           i_btn,
    output logic [2:0]           o_btn_state,
    output logic [2:0]           o_press,
    output logic [CNT_WIDTH-1:0] o_count,
    output logic                 o_wrap
);
    localparam logic [19:0]          DB_LAST = 20'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_WIDTH-1:0] ONE     = CNT_WIDTH'(1);
    logic [2:0]           r_sync1, r_sync2, r_state, r_prev, r_press;
    logic [19:0]          r_db [3];
    logic [CNT_WIDTH-1:0] r_count, w_count_nxt;
    logic                 r_wrap, w_wrap_nxt;
    logic [2:0]           w_lvl;
    logic                 w_up, w_dn, w_clr, w_max, w_zero;
    assign w_lvl  = ~r_sync2;
    assign w_up   = r_press[0];
    assign w_dn   = r_press[1];
    assign w_clr  = r_press[2];
    assign w_max  = &r_count;
    assign w_zero = ~|r_count;
    // Synchronizers idle at 1 so a button held through reset must re-qualify.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_sync1 <= '1;
            r_sync2 <= '1;
            r_state <= '0;
            for (int i = 0; i < 3; i++) r_db[i] <= '0;
        end else begin
            r_sync1 <= i_btn;
            r_sync2 <= r_sync1;
            for (int i = 0; i < 3; i++) begin
                if (w_lvl[i] == r_state[i]) begin
                    r_db[i] <= '0;
                end else if (r_db[i] == DB_LAST) begin
                    r_db[i]    <= '0;
                    r_state[i] <= ~r_state[i];
                end else begin
                    r_db[i] <= r_db[i] + 20'd1;
                end
            end
        end
    end
    always_ff @(posedge clk) begin
        if (rst) begin
            r_prev  <= '0;
            r_press <= '0;
            r_count <= '0;
            r_wrap  <= 1'b0;
        end else begin
            r_prev  <= r_state;
            r_press <= r_state & ~r_prev;
            r_count <= w_count_nxt;
            r_wrap  <= w_wrap_nxt;
        end
    end
    always_comb begin
        w_count_nxt = r_count;
        w_wrap_nxt  = 1'b0;
        if (w_clr) begin
            w_count_nxt = '0;
        end else if (w_up && !w_dn) begin
`ifdef BTN_COUNTER_SATURATE_EN
            w_count_nxt = w_max ? r_count : r_count + ONE;
`else
            w_count_nxt = r_count + ONE;
            w_wrap_nxt  = w_max;
`endif
        end else if (w_dn && !w_up) begin
`ifdef BTN_COUNTER_SATURATE_EN
            w_count_nxt = w_zero ? r_count : r_count - ONE;
`else
            w_count_nxt = r_count - ONE;
            w_wrap_nxt  = w_zero;
`endif
        end
    end
    assign o_btn_state = r_state;
    assign o_press     = r_press;
    assign o_count     = r_count;
    assign o_wrap      = r_wrap;
endmodule
